// File: rtl/hs_pkg.sv
// Shared types and helpers for the hs_utils handshake family.
package hs_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Index width for an N-way selector; never narrower than one bit.
    function automatic int hs_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping mod N.
module hs_rr_pick
    import hs_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = hs_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic           found;

    // Doubling the vector turns the wrap-around search into a plain shift + priority encode.
    assign dbl = {req, req};
    assign rot = dbl >> ptr;
    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = IDX_W'((int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter; holds the grant while the downstream stalls.
// Handshake: a beat moves on a port when its valid and ready are both high at the rising clock edge.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDTH = 1,
    localparam int IDX_W = hs_idx_w(N)
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    input  logic               flush,
    input  logic [N*WIDTH-1:0] in,
    input  logic [N-1:0]       valid_i,
    output logic [N-1:0]       ready_o,
    output logic [WIDTH-1:0]   out,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               state_dbg,
    output logic [IDX_W-1:0]   ptr_dbg,
    output logic [IDX_W-1:0]   lock_dbg
);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] winner;
    logic [WIDTH-1:0] in_arr [N];

    hs_rr_pick #(.N(N)) u_pick (
        .req (valid_i),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign in_arr[i]  = in[i*WIDTH +: WIDTH];
        assign ready_o[i] = ready_i & valid_o & (winner == IDX_W'(i));
    end

    // Once locked the grant ignores new requests so out/grant_o stay frozen across a stall.
    assign winner  = (state == LOCKED) ? lock_idx : pick_idx;
    assign valid_o = (state == LOCKED) ? valid_i[lock_idx] : pick_any;
    assign grant_o = valid_o ? winner : '0;
    assign out     = valid_o ? in_arr[winner] : '0;

    assign state_dbg = state;
    assign ptr_dbg   = ptr;
    assign lock_dbg  = lock_idx;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else if (flush) begin
            state <= IDLE;
            ptr   <= '0;
        end else if (valid_o && ready_i) begin
            state <= IDLE;
            ptr   <= (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;
        end else if (valid_o) begin
            state    <= LOCKED;
            lock_idx <= winner;
        end
    end

endmodule

// File: doc/hs_rr_arbiter.md
# hs_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready handshake port between N upstream requesters in the `hs_utils` family. It sits in front of a shared skid buffer or pipeline stage, for example several issue sources feeding one execution or memory port. It forwards the granted requester's payload combinationally and holds the grant while the transfer is stalled. Priority rotates after every accepted transfer, and `flush` drops all arbitration state.

## Interface
- `N`, default 2: number of requesters, legal values 2..16.
- `WIDTH`, default 1: payload width in bits.
- `IDX_W`, default `$clog2(N)`: derived localparam, width of the grant index.
- `clk_core`  in  1  core clock; all state updates on its rising edge.
- `rst_core_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous pipeline flush.
- `in`  in  N×WIDTH  per-requester payload.
- `valid_i`  in  N  per-requester valid.
- `ready_o`  out  N  per-requester ready; at most one bit is set.
- `out`  out  WIDTH  granted payload.
- `valid_o`  out  1  downstream valid.
- `ready_i`  in  1  downstream ready.
- `grant_o`  out  IDX_W  index of the current grant; meaningful only while `valid_o`=1.

## Operation
- **State:**
  - `ptr` (IDX_W): highest-priority requester index.
  - FSM: `IDLE` or `LOCKED`.
  - `lock_idx` (IDX_W): the held grant while `LOCKED`.
- **Reset:** `ptr`=0, FSM=`IDLE`, `lock_idx`=0.
- **IDLE:**
  - Winner = first `i` with `valid_i[i]`=1, searching `ptr`, `ptr+1`, … mod N.
  - `valid_o` = OR of `valid_i`.
  - `grant_o` = winner; `out` = `in[winner]`.
  - `ready_o[winner]` = `ready_i`.
- **LOCKED:**
  - Winner = `lock_idx`, regardless of other requesters.
  - `valid_o` = `valid_i[lock_idx]`.
  - `out` and `grant_o` are taken from `lock_idx`.
  - `ready_o[lock_idx]` = `ready_i`.
- **No request:** `valid_o`=0, `ready_o`=0, `out`='0, `grant_o`=0.
- **Transitions, evaluated at the clock edge with `flush`=0:**
  - `valid_o` & `ready_i` (transfer): FSM→`IDLE`, `ptr` ← (winner+1) mod N.
  - `valid_o` & ~`ready_i` (stall): FSM→`LOCKED`, `lock_idx` ← winner. In `LOCKED` the FSM and `lock_idx` stay unchanged.
  - `~valid_o`: no change.
- **Protocol:**
  - Requesters obey the valid/ready contract: `valid_i` and `in` are held until `ready_o`.
  - The lock guarantees `out` and `grant_o` are stable while stalled, even if a higher-priority requester raises valid.
  - If a locked requester drops valid (protocol violation), `valid_o` falls and the lock is kept.
- **Flush:** FSM→`IDLE` and `ptr`←0 at the edge. `flush` does not gate combinational outputs in that cycle; downstream flushes in parallel.
- **Pointer wrap:** winner N−1 transfers → `ptr`=0.

## Timing
- Payload, valid and ready paths are combinational: zero-cycle latency, one transfer per cycle sustained.
- There is no combinational path from `ready_i` to `grant_o` or `valid_o`. The path `ready_i`→`ready_o` is a single AND.
- Output values during reset:
  - `valid_o` = OR of `valid_i`, with `grant_o`/`out` from the `ptr`=0 search.
  - `ready_o[winner]` = `ready_i`.
  - The downstream is itself held in reset, so no transfer is taken.
- **Reset mid-transfer:** the lock and pointer are lost asynchronously.
- **Simultaneous flush and transfer:** flush wins, `ptr`=0.
- **Single active requester:** granted every cycle with no bubbles.

## Structure
- `hs_pkg` holds the `hs_idx_w(N)` helper function.
- Sub-module `hs_rr_pick #(N)`: a purely combinational rotating-priority picker.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `any`, `idx`.
  - Implemented as a double-width request vector with priority encoding.
  - Reused by future arbiters.
- The top level holds the FSM, `ptr`, `lock_idx` and the output mux.

## Test plan
All scenarios use N=3, WIDTH=8.
1. **Rotation.** Reset; hold `valid_i`=3'b111 with `in`={8'h33, 8'h22, 8'h11} (requesters 2, 1, 0) and `ready_i`=1 for 4 cycles → `grant_o` = 0, 1, 2, 0; `out` = 11, 22, 33, 11.
2. **Stall lock.** `ptr`=0; only requester 2 is valid with `in`=8'hA5 and `ready_i`=0 for 3 cycles; requester 0 raises valid in cycle 2.
   - → `grant_o`=2 and `out`=A5 stay stable.
   - → `ready_o` stays 0 throughout.
   - When `ready_i`=1: transfer from requester 2, then `ptr`=0, so requester 0 is granted next.
3. **Wrap.** Grant requester 2, then transfer → `ptr`=0.
   - Next, `valid_i`=3'b011 → `grant_o`=0.
4. **Flush.** `LOCKED` on requester 1 with `ptr`=1; pulse `flush` → next cycle the FSM is `IDLE`.
   - With `valid_i`=3'b110 → `grant_o`=1, because `ptr`=0.
5. **Async reset.** `LOCKED` on requester 2, `ptr`=2; drop `rst_core_n` mid-cycle → state clears immediately.
   - After release with `valid_i`=3'b111 → `grant_o`=0.
6. **Idle.** `valid_i`=0 → `valid_o`=0, `ready_o`=0, `out`=0.
   - `ready_i` toggling changes neither `ptr` nor the FSM state.
